// File: rtl/timer_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : timer_capture_if
//  Brief    : Bus bundle between a timer-capture block and its host.
//  Revision : 1.0
// ============================================================================
interface timer_capture_if #(
    parameter int COUNTER_SIZE = 8,
    parameter int DEPTH        = 4
);
    logic                      en;
    logic                      cap_in;
    logic [1:0]                edge_sel;
    logic [COUNTER_SIZE-1:0]   cnt_value;
    logic                      rd_req;
    logic                      clr_ovf;
    logic [COUNTER_SIZE-1:0]   cap_data;
    logic                      cap_valid;
    logic [$clog2(DEPTH):0]    cap_level;
    logic                      cap_ovf;
    logic                      irq;

    modport master (
        output en, cap_in, edge_sel, cnt_value, rd_req, clr_ovf,
        input  cap_data, cap_valid, cap_level, cap_ovf, irq
    );

    modport slave (
        input  en, cap_in, edge_sel, cnt_value, rd_req, clr_ovf,
        output cap_data, cap_valid, cap_level, cap_ovf, irq
    );
endinterface
`default_nettype wire

// File: rtl/timer_capture.sv
`default_nettype none
// ============================================================================
//  Module   : timer_capture
//  Brief    : Edge-triggered counter capture into a FIFO with overflow flag.
//             Optional glitch filter enabled by TIMER_CAPTURE_FILTER_EN.
//  Revision : 1.0
// ============================================================================
module timer_capture #(
    parameter int COUNTER_SIZE = 8,
    parameter int DEPTH        = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    timer_capture_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic s1_q, s2_q, s3_q;
    logic lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.cap_in;
            s2_q <= s1_q;
            s3_q <= lvl_d;
        end
    end

`ifdef TIMER_CAPTURE_FILTER_EN
    // s3 holds the filtered level; it only moves when three s2 samples agree.
    logic h1_q, h2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_q <= 1'b0;
            h2_q <= 1'b0;
        end else begin
            h1_q <= s2_q;
            h2_q <= h1_q;
        end
    end

    always_comb begin
        lvl_d = s3_q;
        if (s2_q & h1_q & h2_q)
            lvl_d = 1'b1;
        else if (~(s2_q | h1_q | h2_q))
            lvl_d = 1'b0;
    end
`else
    assign lvl_d = s2_q;
`endif

    logic rise_w, fall_w, event_w;

    assign rise_w  = lvl_d & ~s3_q;
    assign fall_w  = ~lvl_d & s3_q;
    assign event_w = bus.en & ((rise_w & bus.edge_sel[0]) | (fall_w & bus.edge_sel[1]));

    logic [AW-1:0]           rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]             level_q, level_d;
    logic                    ovf_q, ovf_d;
    logic                    full_w, pop_w, push_w;
    logic [COUNTER_SIZE-1:0] mem_q [DEPTH];

    assign full_w = (level_q == C_FULL);
    assign pop_w  = bus.rd_req & (level_q != '0);
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign push_w = event_w & (~full_w | pop_w);

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (pop_w)
            rptr_d = rptr_q + AW'(1);
        if (push_w)
            wptr_d = wptr_q + AW'(1);
        if (push_w & ~pop_w)
            level_d = level_q + (AW+1)'(1);
        else if (pop_w & ~push_w)
            level_d = level_q - (AW+1)'(1);
        if (event_w & full_w & ~pop_w)
            ovf_d = 1'b1;
        else if (bus.clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w)
            mem_q[wptr_q] <= bus.cnt_value;
    end

    assign bus.cap_valid = (level_q != '0);
    assign bus.cap_data  = bus.cap_valid ? mem_q[rptr_q] : '0;
    assign bus.cap_level = level_q;
    assign bus.cap_ovf   = ovf_q;
    assign bus.irq       = bus.cap_valid | ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_capture
//  Brief    : Self-checking bench for timer_capture with a queue-based model.
//  Revision : 1.0
// ============================================================================
module tb_timer_capture;
    localparam int CS    = 8;
    localparam int DEPTH = 4;
`ifdef TIMER_CAPTURE_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_capture_if #(.COUNTER_SIZE(CS), .DEPTH(DEPTH)) bus ();

    timer_capture #(.COUNTER_SIZE(CS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [CS-1:0] q[$];     // expected FIFO contents, head at index 0
    bit            m_ovf;
    bit            samp[$];  // cap_in as sampled at past edges, newest first
    bit            m_filt;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_filt = 1'b0;
        samp   = '{1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    // Called just after a rising edge; inputs are stable since the last falling edge.
    task automatic model_edge();
        bit cur, prev, rise, fall, ev, pop, full;
`ifdef TIMER_CAPTURE_FILTER_EN
        prev = m_filt;
        if (samp[1] && samp[2] && samp[3]) m_filt = 1'b1;
        else if (!samp[1] && !samp[2] && !samp[3]) m_filt = 1'b0;
        cur = m_filt;
`else
        cur  = samp[1];
        prev = samp[2];
`endif
        rise = cur && !prev;
        fall = !cur && prev;
        ev   = bus.en && ((rise && bus.edge_sel[0]) || (fall && bus.edge_sel[1]));
        pop  = bus.rd_req && (q.size() != 0);
        full = (q.size() == DEPTH);
        if (ev && full && !pop) begin
            m_ovf = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (ev) q.push_back(bus.cnt_value);
            if (bus.clr_ovf) m_ovf = 1'b0;
        end
        samp.push_front(bus.cap_in);
        void'(samp.pop_back());
    endtask

    task automatic compare();
        chk("cap_valid", 32'(bus.cap_valid), 32'(q.size() != 0));
        chk("cap_level", 32'(bus.cap_level), 32'(q.size()));
        if (q.size() != 0) chk("cap_data", 32'(bus.cap_data), 32'(q[0]));
        chk("cap_ovf", 32'(bus.cap_ovf), 32'(m_ovf));
        chk("irq", 32'(bus.irq), 32'((q.size() != 0) || m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        bus.cnt_value = bus.cnt_value + CS'(1);
    endtask

    task automatic hold(input bit v, input int n);
        bus.cap_in = v;
        repeat (n) step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.cap_valid), 32'd0);
        chk({tag, "_level"}, 32'(bus.cap_level), 32'd0);
        chk({tag, "_data"},  32'(bus.cap_data),  32'd0);
        chk({tag, "_ovf"},   32'(bus.cap_ovf),   32'd0);
        chk({tag, "_irq"},   32'(bus.irq),       32'd0);
    endtask

    // Reset is raised between edges so the outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.cap_in    = 1'b0;
        bus.edge_sel  = 2'b00;
        bus.cnt_value = '0;
        bus.rd_req    = 1'b0;
        bus.clr_ovf   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        hold(1'b0, 4);

        // Single rising capture of the counter value at the capture edge
        bus.en        = 1'b1;
        bus.edge_sel  = 2'b01;
        bus.cnt_value = 8'h10;
        bus.cap_in    = 1'b1;
        repeat (LAT - 1) begin
            step();
            chk("latency_early_valid", 32'(bus.cap_valid), 32'd0);
        end
        step();
        chk("first_valid", 32'(bus.cap_valid), 32'd1);
        chk("first_data", 32'(bus.cap_data), (LAT == 3) ? 32'h12 : 32'h14);
        chk("first_irq", 32'(bus.irq), 32'd1);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        chk("first_popped", 32'(bus.cap_valid), 32'd0);

        // Five rising events, no reads: overflow keeps the first four
        hold(1'b0, 6);
        repeat (5) begin
            hold(1'b1, 4);
            hold(1'b0, 4);
        end
        hold(1'b0, LAT);
        chk("full_level", 32'(bus.cap_level), 32'd4);
        chk("full_ovf", 32'(bus.cap_ovf), 32'd1);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        chk("clr_ovf", 32'(bus.cap_ovf), 32'd0);
        chk("clr_keeps_level", 32'(bus.cap_level), 32'd4);

        // Full FIFO with event coincident with a pop
        bus.cap_in = 1'b1;
        repeat (LAT - 1) step();
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        chk("coincident_level", 32'(bus.cap_level), 32'd4);
        chk("coincident_ovf", 32'(bus.cap_ovf), 32'd0);

        // Drain, then pop on empty
        bus.rd_req = 1'b1;
        repeat (6) step();
        bus.rd_req = 1'b0;
        chk("empty_rd_level", 32'(bus.cap_level), 32'd0);
        chk("empty_rd_valid", 32'(bus.cap_valid), 32'd0);

        // Toggles while disabled, then enable on a steady level
        bus.en       = 1'b0;
        bus.edge_sel = 2'b11;
        hold(1'b0, 6);
        hold(1'b1, 6);
        hold(1'b0, 6);
        hold(1'b1, 6);
        bus.en = 1'b1;
        repeat (8) step();
        chk("enable_steady_level", 32'(bus.cap_level), 32'd0);

        // Three entries plus overflow, then async reset with cap_in high
        hold(1'b0, 8);
        hold(1'b1, 8);
        hold(1'b0, 8);
        hold(1'b1, 8);
        hold(1'b0, 8);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        chk("pre_rst_level", 32'(bus.cap_level), 32'd3);
        chk("pre_rst_ovf", 32'(bus.cap_ovf), 32'd1);
        bus.cap_in = 1'b1;
        do_reset();
        repeat (LAT + 3) step();
        chk("post_rst_one_capture", 32'(bus.cap_level), 32'd1);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;

`ifdef TIMER_CAPTURE_FILTER_EN
        bus.edge_sel = 2'b01;
        hold(1'b0, 8);
        hold(1'b1, 2);
        hold(1'b0, 10);
        chk("glitch_rejected", 32'(bus.cap_level), 32'd0);
        hold(1'b1, 4);
        chk("filtered_not_yet", 32'(bus.cap_level), 32'd0);
        hold(1'b0, 1);
        chk("filtered_capture", 32'(bus.cap_level), 32'd1);
        hold(1'b0, 8);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
`endif

        // Randomized traffic, all compared against the model every cycle
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 3) == 0) bus.cap_in = 1'($urandom);
            bus.en = (($urandom % 8) != 0);
            if (($urandom % 50) == 0) bus.edge_sel = 2'($urandom);
            bus.rd_req  = ($urandom_range(0, 99) < ((((i / 300) % 2) != 0) ? 60 : 12));
            bus.clr_ovf = (($urandom % 40) == 0);
            bus.cnt_value = CS'($urandom);
            step();
            if ((i % 997) == 996) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
